// File: rtl/ah_cpu2pl_src_arbiter.sv
// Round-robin arbiter sharing one CPU2PL input/interrupt slot among NUM_REQ PL producers.
// Grants one producer, latches its word, pulses slot_intr and holds until the CPU acknowledges.
module ah_cpu2pl_src_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int REQUIRE_READ_ACK = 1,
    parameter int ACK_TIMEOUT      = 1024,
    localparam int SRC_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         slot_data,
    output logic [SRC_W-1:0]              slot_src,
    output logic                          slot_intr,
    input  logic                          intr_ack,
    input  logic                          read_ack,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int          CNT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t                  state_q, state_d;
    logic [SRC_W-1:0]        rr_q, rr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [SRC_W-1:0]        src_q, src_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;
    logic                    intr_q, intr_d;
    logic                    ai_q, ai_d;
    logic                    ar_q, ar_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    terr_q, terr_d;

    logic                    found;
    logic [SRC_W-1:0]        win;
    logic [DATA_WIDTH-1:0]   win_word;
    logic [NUM_REQ-1:0]      win_hot;
    logic                    done;
    logic                    timeout_hit;

    // First requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[SRC_W'(idx)]) begin
                found = 1'b1;
                win   = SRC_W'(idx);
            end
        end
        win_word = '0;
        win_hot  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == SRC_W'(i)) begin
                win_word   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_hot[i] = 1'b1;
            end
        end
    end

    assign done        = (ai_q | intr_ack) && (ar_q | read_ack | (REQUIRE_READ_ACK == 0));
    assign timeout_hit = (ACK_TIMEOUT > 0) && (32'(cnt_q) == TO_LAST);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        data_d  = data_q;
        src_d   = src_q;
        ready_d = '0;
        intr_d  = 1'b0;
        ai_d    = ai_q;
        ar_d    = ar_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    data_d  = win_word;
                    src_d   = win;
                    ready_d = win_hot;
                    intr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                    if (32'(win) == NUM_REQ - 1) rr_d = '0;
                    else                         rr_d = win + SRC_W'(1);
                end
            end
            WAIT_ACK: begin
                ai_d  = ai_q | intr_ack;
                ar_d  = ar_q | read_ack;
                cnt_d = cnt_q + CNT_W'(1);
                // A release on the timeout's last cycle is a normal one, not an error.
                if (done || timeout_hit) begin
                    terr_d  = !done;
                    state_d = IDLE;
                    ai_d    = 1'b0;
                    ar_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= IDLE;
            rr_q    <= '0;
            data_q  <= '0;
            src_q   <= '0;
            ready_q <= '0;
            intr_q  <= 1'b0;
            ai_q    <= 1'b0;
            ar_q    <= 1'b0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ready_q <= ready_d;
            intr_q  <= intr_d;
            ai_q    <= ai_d;
            ar_q    <= ar_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign req_ready   = ready_q;
    assign slot_data   = data_q;
    assign slot_src    = src_q;
    assign slot_intr   = intr_q;
    assign busy        = (state_q == WAIT_ACK);
    assign timeout_err = terr_q;

endmodule
